// File: rtl/raw_serial_pkg.sv
// raw_serial_pkg: link-wide defaults and receiver state encoding for the raw serial link.
package raw_serial_pkg;
  localparam int RS_CLKS_PER_BIT = 256;
  localparam int RS_DATA_BITS    = 8;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
endpackage

// File: rtl/serial_sync2.sv
// serial_sync2: two-flop synchronizer for an asynchronous input, reset value selectable.
module serial_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {2{RST_VAL}};
    else r_sync <= {r_sync[0], i_d};
  end
  assign o_q = r_sync[1];
endmodule

// File: rtl/raw_serial_rx.sv
// raw_serial_rx: 8N1 serial receiver delivering bytes on valid/ready,
// with one-cycle frame_err and overrun pulses.
module raw_serial_rx
  import raw_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = RS_CLKS_PER_BIT,
  parameter int DATA_BITS    = RS_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] H_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  logic                 w_rxs, w_tick, w_fall;
  logic                 r_rxs_d;
  logic [1:0]           r_settle;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_ferr, r_ovr;
  serial_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rxd),
    .o_q  (w_rxs)
  );
  assign w_tick    = r_cnt == '0;
  assign w_fall    = ~w_rxs & r_rxs_d;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  // r_rxs_d only follows the line once the synchronizer has flushed its reset
  // value, so a line already low at reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_rxs_d  <= 1'b0;
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_settle <= {r_settle[0], 1'b1};
      r_rxs_d  <= r_settle[1] & w_rxs;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      if (r_valid && rx_ready) r_valid <= 1'b0;
      case (r_state)
        RX_IDLE: if (w_fall) begin
          r_state <= RX_START;
          r_cnt   <= H_LOAD;
        end
        RX_START: begin
          r_cnt <= w_tick ? C_LOAD : r_cnt - 1'b1;
          r_idx <= '0;
          if (w_tick) r_state <= w_rxs ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          r_cnt <= w_tick ? C_LOAD : r_cnt - 1'b1;
          if (w_tick) begin
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == I_LAST) r_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          r_cnt <= w_tick ? C_LOAD : r_cnt - 1'b1;
          if (w_tick) begin
            r_state <= w_rxs ? RX_IDLE : RX_BREAK;
            r_ferr  <= ~w_rxs;
            // a held, unaccepted byte wins over the new one
            if (w_rxs && r_valid && !rx_ready) r_ovr <= 1'b1;
            else if (w_rxs) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end
        end
        RX_BREAK: if (w_rxs) r_state <= RX_IDLE;
        default: r_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_raw_serial_rx.sv
// tb_raw_serial_rx: ideal 8N1 transmitter driving raw_serial_rx; deliveries checked
// for value and exact cycle against timing computed from the frame start.
module tb_raw_serial_rx;
  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 2 + H + 9 * C + 1;
  logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  int         cyc = 0, n_chk = 0, n_fail = 0;
  int         fe_cnt = 0, ov_cnt = 0, fe_cyc = -1, ov_cyc = -1;
  bit         hold = 1'b0;
  logic [7:0] dq[$];
  int         dc[$];
  typedef struct {
    logic [7:0] d;
    logic       sb;
    int         low;
    logic       ev;
    logic       ef;
  } vec_t;
  vec_t tbl[6];
  raw_serial_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hold <= rx_valid & ~rx_ready;
  end
  // a delivery is a cycle where rx_valid shows a byte not already held from before
  always @(negedge clk) if (rst_n) begin
    if (rx_valid && !hold) begin
      dq.push_back(rx_data);
      dc.push_back(cyc);
    end
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic sb, output int n);
    n = cyc;
    rxd = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      idle(C);
    end
    rxd = sb;
    idle(C);
    rxd = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, n2, b0, f0, o0, dummy;
    logic [7:0] d;
    logic [7:0] eq[$];
    int ec[$];
    tbl[0] = '{8'h41, 1'b1, 0, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 1'b1, 0, 1'b1, 1'b0};
    tbl[4] = '{8'h7E, 1'b0, 100, 1'b0, 1'b1};
    tbl[5] = '{8'h12, 1'b1, 0, 1'b1, 1'b0};
    rxd = 1'b0;
    idle(3);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(200);
    chk("low_at_reset_no_data", dq.size(), 0);
    chk("low_at_reset_no_ferr", fe_cnt, 0);
    rxd = 1'b1;
    idle(20);
    foreach (tbl[i]) begin
      b0 = dq.size();
      f0 = fe_cnt;
      o0 = ov_cnt;
      send_frame(tbl[i].d, tbl[i].sb, n);
      if (tbl[i].low > 0) begin
        rxd = 1'b0;
        idle(tbl[i].low);
        rxd = 1'b1;
      end
      idle(20);
      chk($sformatf("vec%0d_deliveries", i), dq.size() - b0, 32'(tbl[i].ev));
      if (tbl[i].ev && dq.size() > b0) begin
        chk($sformatf("vec%0d_data", i), dq[b0], tbl[i].d);
        chk($sformatf("vec%0d_cycle", i), dc[b0], n + LAT);
      end
      chk($sformatf("vec%0d_ferr_pulses", i), fe_cnt - f0, 32'(tbl[i].ef));
      if (tbl[i].ef) chk($sformatf("vec%0d_ferr_cycle", i), fe_cyc, n + LAT);
      chk($sformatf("vec%0d_ovr", i), ov_cnt - o0, 0);
    end
    b0 = dq.size();
    f0 = fe_cnt;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    chk("glitch_no_data", dq.size() - b0, 0);
    chk("glitch_no_ferr", fe_cnt - f0, 0);
    send_frame(8'h3C, 1'b1, n);
    idle(20);
    chk("after_glitch_cnt", dq.size() - b0, 1);
    chk("after_glitch_data", dq[b0], 8'h3C);
    chk("after_glitch_cycle", dc[b0], n + LAT);
    b0 = dq.size();
    send_frame(8'h55, 1'b1, n);
    send_frame(8'hAA, 1'b1, n2);
    idle(20);
    chk("b2b_cnt", dq.size() - b0, 2);
    chk("b2b_data0", dq[b0], 8'h55);
    chk("b2b_data1", dq[b0+1], 8'hAA);
    chk("b2b_cycle0", dc[b0], n + LAT);
    chk("b2b_spacing", dc[b0+1] - dc[b0], 10 * C);
    b0 = dq.size();
    o0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1, n);
    send_frame(8'h02, 1'b1, n2);
    idle(5);
    chk("ovr_deliveries", dq.size() - b0, 1);
    chk("ovr_held_data", rx_data, 8'h01);
    chk("ovr_held_valid", rx_valid, 1);
    chk("ovr_pulses", ov_cnt - o0, 1);
    chk("ovr_cycle", ov_cyc, n2 + LAT);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_accepted", rx_valid, 0);
    rx_ready = 1'b0;
    b0 = dq.size();
    o0 = ov_cnt;
    send_frame(8'h21, 1'b1, n);
    n2 = cyc;
    fork
      send_frame(8'h22, 1'b1, dummy);
      begin
        idle(LAT - 1);
        rx_ready = 1'b1;
      end
    join
    idle(5);
    chk("same_cycle_cnt", dq.size() - b0, 2);
    chk("same_cycle_data", dq[b0+1], 8'h22);
    chk("same_cycle_cycle", dc[b0+1], n2 + LAT);
    chk("same_cycle_no_ovr", ov_cnt - o0, 0);
    chk("same_cycle_drained", rx_valid, 0);
    b0 = dq.size();
    f0 = fe_cnt;
    o0 = ov_cnt;
    fork
      send_frame(8'hF0, 1'b1, dummy);
      begin
        idle(5 * C + 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data", rx_data, 0);
        chk("midrst_valid", rx_valid, 0);
        idle(2);
        rst_n = 1'b1;
      end
    join
    idle(20);
    chk("midrst_no_data", dq.size() - b0, 0);
    chk("midrst_no_ferr", fe_cnt - f0, 0);
    chk("midrst_no_ovr", ov_cnt - o0, 0);
    send_frame(8'h99, 1'b1, n);
    idle(20);
    chk("after_rst_cnt", dq.size() - b0, 1);
    chk("after_rst_data", dq[b0], 8'h99);
    chk("after_rst_cycle", dc[b0], n + LAT);
    b0 = dq.size();
    f0 = fe_cnt;
    o0 = ov_cnt;
    for (int k = 0; k < 20; k++) begin
      idle($urandom_range(0, 30));
      d = 8'($urandom);
      eq.push_back(d);
      ec.push_back(cyc + LAT);
      send_frame(d, 1'b1, n);
    end
    idle(20);
    chk("rand_cnt", dq.size() - b0, 20);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("rand%0d_data", k), dq[b0+k], eq[k]);
      chk($sformatf("rand%0d_cycle", k), dc[b0+k], ec[k]);
    end
    chk("rand_no_ferr", fe_cnt - f0, 0);
    chk("rand_no_ovr", ov_cnt - o0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/raw_serial_rx.md
Name: raw_serial_rx

Overview:
- UART-style serial receiver: the receive end of the project's raw serial link.
- Recovers 8N1 frames from an asynchronous line: idle high, one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
- Timing comes from a clock-cycle bit counter derived from clk.
- Delivers each byte on a valid/ready interface to downstream logic (LED/debug sink, FIFO), with framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 256, clk cycles per bit period. Must be >= 4.
- DATA_BITS, 8, data bits per frame. Legal range 5..8.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset; release is synchronous to clk
- rxd  input  1  serial line, asynchronous to clk, idle high
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid & rx_ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: completed byte dropped because rx_valid was still held

Behaviour:
- Reset (rst_n=0, async):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Input path: rxd passes through a 2-flop synchronizer, giving rxs (2-cycle delay). A registered copy rxs_d is used for edge detect.
- H = CLKS_PER_BIT/2 (integer division). C = CLKS_PER_BIT.
- IDLE:
  - On rxs=0 and rxs_d=1 (falling edge, cycle T), load the bit counter and go to START.
  - A line held low out of reset does not start a frame; a falling edge is required.
- START:
  - Sample rxs at T+H.
  - rxs=1 -> glitch/false start; return to IDLE with no flags.
  - rxs=0 -> go to DATA with bit index 0.
- DATA:
  - Sample data bit i at T+H+(i+1)*C into a shift register, LSB first.
  - After bit DATA_BITS-1, go to STOP.
- STOP: sample at T+H+(DATA_BITS+1)*C.
  - rxs=1 -> frame good. In the next cycle, load rx_data and set rx_valid; return to IDLE.
  - rxs=0 -> pulse frame_err for exactly one cycle. No data is delivered and existing rx_valid/rx_data are untouched. Go to BREAK.
- BREAK: wait until rxs=1, then IDLE. A held-low line (break) produces exactly one frame_err.
- Latency: rx_valid rises at cycle T+H+(DATA_BITS+1)*C+1. T is 2 cycles after the rxd falling edge, due to the synchronizer.
- Handshake:
  - rx_valid stays 1 and rx_data stays constant until the cycle after rx_valid&rx_ready.
  - rx_ready is ignored while rx_valid=0.
- Completion with rx_valid=1 and rx_ready=0: new byte discarded, old byte kept, overrun pulses for one cycle.
- Completion in the same cycle as acceptance (rx_valid&rx_ready): the new byte is loaded, rx_valid stays 1, no overrun.
- Back-to-back frames: a new start edge is detected immediately once IDLE is re-entered, i.e. during the stop bit's second half. Zero inter-frame gap is supported.
- Counter width: $clog2(CLKS_PER_BIT). Bit counter counts down and reloads with C-1 at each sample point; no wrap-around is visible outside the module.
- Reset asserted mid-frame: immediate return to the reset state. The partial byte is lost and no flags are raised. After release, the receiver waits for a fresh falling edge.

Decomposition:
- Package raw_serial_pkg:
  - rx state enum (IDLE, START, DATA, STOP, BREAK).
  - Default CLKS_PER_BIT=256 and DATA_BITS=8 constants, shared with the transmitter.
- One sub-module: serial_sync2, a 2-flop synchronizer with parameterised reset value (here 1). Reusable for other async inputs.

Test Plan (bench uses CLKS_PER_BIT=16, DATA_BITS=8, ideal TX model):
- Send 0x41 with rx_ready=1 -> rx_valid one cycle, rx_data=0x41 at exactly T+8+9*16+1. frame_err=0, overrun=0.
- Send 0x55 then 0xAA back-to-back with zero gap, rx_ready=1 -> two deliveries, 0x55 then 0xAA, 160 cycles apart.
- Low glitch of 4 cycles on idle line -> no rx_valid, no frame_err; a following 0x3C frame is received correctly.
- Frame 0x7E with stop bit forced 0, then line held low 100 cycles -> exactly one frame_err pulse, no rx_valid. The next valid 0x12 is received.
- rx_ready=0, send 0x01 then 0x02 -> rx_data stays 0x01, overrun pulses once at the second completion. Raising rx_ready then accepts 0x01.
- rst_n pulsed low during data bit 4 of 0xF0 -> outputs return to 0. No delivery for that frame; the next frame 0x99 is received correctly.
